// File: rtl/irq_pend_ctrl_pkg.sv
// Shared constants and types for the interrupt pending front end.
// The priority encoder and the controller both import this package.
package irq_pend_ctrl_pkg;

  localparam int IRQ_N   = 4;
  localparam int IRQ_IDW = 2;

  // Encoder output layout: valid flag above the winning index.
  localparam int ENC_V      = 2;
  localparam int ENC_IDX_HI = 1;
  localparam int ENC_IDX_LO = 0;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_PRESENT = 1'b1
  } state_e;

endpackage

// File: rtl/irq_pend_ctrl_enc.sv
// 4-to-2 priority encoder with valid flag; bit 3 has the highest priority.
// An all-zero or unknown input yields an invalid (y[2]=0) result.
module pri_enc4
  import irq_pend_ctrl_pkg::*;
(
  input  logic [IRQ_N-1:0]   a,
  output logic [IRQ_IDW:0]   y
);

  always_comb begin
    y = '0;
    // Wildcards live only in the case items, so unknown input bits never match.
    case (a) inside
      4'b1???: begin
        y[ENC_V]                 = 1'b1;
        y[ENC_IDX_HI:ENC_IDX_LO] = 2'd3;
      end
      4'b01??: begin
        y[ENC_V]                 = 1'b1;
        y[ENC_IDX_HI:ENC_IDX_LO] = 2'd2;
      end
      4'b001?: begin
        y[ENC_V]                 = 1'b1;
        y[ENC_IDX_HI:ENC_IDX_LO] = 2'd1;
      end
      4'b0001: begin
        y[ENC_V]                 = 1'b1;
        y[ENC_IDX_HI:ENC_IDX_LO] = 2'd0;
      end
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/irq_pend_ctrl.sv
// Interrupt front end: edge capture into pending/overflow registers, masking,
// priority selection and a valid/ack presentation of the winning index.
module irq_pend_ctrl
  import irq_pend_ctrl_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [IRQ_N-1:0]   irq_in,
  input  logic [IRQ_N-1:0]   mask,
  output logic               irq_valid,
  output logic [IRQ_IDW-1:0] irq_id,
  input  logic               irq_ack,
  output logic [IRQ_N-1:0]   pending,
  output logic [IRQ_N-1:0]   ovf,
  input  logic [IRQ_N-1:0]   ovf_clr
);

  logic [IRQ_N-1:0]   irq_prev_q;
  logic [IRQ_N-1:0]   pending_q, pending_d;
  logic [IRQ_N-1:0]   ovf_q, ovf_d;
  logic [IRQ_IDW-1:0] irq_id_q, irq_id_d;
  state_e             state_q, state_d;

  logic [IRQ_N-1:0]   rise;
  logic [IRQ_N-1:0]   ack_clr;
  logic               ack_fire;
  logic [IRQ_IDW:0]   enc_y;

  assign rise     = irq_in & ~irq_prev_q;
  assign ack_fire = (state_q == ST_PRESENT) && irq_ack;

  // The presented line is cleared by ack regardless of its current mask bit.
  genvar gi;
  generate
    for (gi = 0; gi < IRQ_N; gi++) begin : g_clr
      assign ack_clr[gi] = ack_fire && (irq_id_q == IRQ_IDW'(gi));
    end
  endgenerate

  assign pending_d = (pending_q & ~ack_clr) | rise;
  assign ovf_d     = (ovf_q & ~ovf_clr) | (rise & pending_q & ~ack_clr);

  pri_enc4 u_enc (
    .a (pending_q & mask),
    .y (enc_y)
  );

  always_comb begin
    state_d  = state_q;
    irq_id_d = irq_id_q;
    case (state_q)
      ST_IDLE: begin
        if (enc_y[ENC_V]) begin
          state_d  = ST_PRESENT;
          irq_id_d = enc_y[ENC_IDX_HI:ENC_IDX_LO];
        end
      end
      ST_PRESENT: begin
        if (irq_ack) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // History follows irq_in even in reset so lines already high never pend.
    irq_prev_q <= irq_in;
    if (rst) begin
      pending_q <= '0;
      ovf_q     <= '0;
      irq_id_q  <= '0;
      state_q   <= ST_IDLE;
    end else begin
      pending_q <= pending_d;
      ovf_q     <= ovf_d;
      irq_id_q  <= irq_id_d;
      state_q   <= state_d;
    end
  end

  assign irq_valid = (state_q == ST_PRESENT);
  assign irq_id    = irq_id_q;
  assign pending   = pending_q;
  assign ovf       = ovf_q;

endmodule
